// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package counter_pkg;

    localparam logic        CNT_UP   = 1'b1;
    localparam logic        CNT_DOWN = 1'b0;
    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Ceiling log2; sizes the prescaler phase counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prescale_tick.sv
// Clock prescaler: emits a one-cycle step every PRESCALE enabled cycles.
module prescale_tick
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic step
);

    if (PRESCALE <= 1) begin : g_direct
        logic unused_ok;
        assign unused_ok = ^{clk, reset, clear};
        assign step      = en;
    end else begin : g_phase
        localparam int unsigned   PW   = clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] phase_q, phase_d;
        logic          at_last;

        assign at_last = (phase_q == LAST);
        assign step    = en && at_last;

        // en=0 freezes the phase rather than clearing it
        always_comb begin
            phase_d = phase_q;
            if (clear) begin
                phase_d = '0;
            end else if (en) begin
                phase_d = at_last ? '0 : phase_q + PW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with prescaler, clear, load,
// wrap/saturate limit handling and a registered terminal-count strobe.
module param_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int unsigned     PRESCALE = 1,
    parameter int unsigned     SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("param_updown_counter: MODULUS must be 2..2**WIDTH");
    end
    if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_prescale
        $error("param_updown_counter: PRESCALE must be 1..65536");
    end
    if (SATURATE > CNT_SAT) begin : g_bad_saturate
        $error("param_updown_counter: SATURATE must be 0 or 1");
    end

    // One extra bit so MODULUS == 2**WIDTH is representable
    localparam logic [WIDTH:0] MOD_C         = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_C         = (WIDTH + 1)'(MODULUS - 1);
    localparam bit             HOLD_AT_LIMIT = (SATURATE != CNT_WRAP);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             step;
    logic             at_max, at_zero;
    logic [WIDTH-1:0] load_cnt;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .clear (clear | load),
        .en    (en),
        .step  (step)
    );

    assign at_max   = ({1'b0, count_q} == MAX_C);
    assign at_zero  = (count_q == '0);
    assign load_cnt = ({1'b0, load_val} < MOD_C) ? load_val : MAX_C[WIDTH-1:0];

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_cnt;
        end else if (step) begin
            case (up)
                CNT_UP: begin
                    if (at_max) begin
                        tc_d = 1'b1;
                        if (!HOLD_AT_LIMIT) count_d = '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                CNT_DOWN: begin
                    if (at_zero) begin
                        tc_d = 1'b1;
                        if (!HOLD_AT_LIMIT) count_d = MAX_C[WIDTH-1:0];
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: four configurations share one stimulus stream.
module tb_param_updown_counter;

    localparam int NDUT = 4;
    localparam int MODS [NDUT] = '{16, 10, 10, 10};
    localparam int PRES [NDUT] = '{1, 1, 1, 3};
    localparam int SATS [NDUT] = '{0, 0, 1, 0};

    logic       clk = 1'b0;
    logic       reset, clear, load, en, up;
    logic [3:0] load_val;
    logic [3:0] cnt [NDUT];
    logic       tcs [NDUT];

    int total = 0;
    int bad   = 0;

    // reference state: count, prescaler phase, tc per instance
    int mc [NDUT];
    int mp [NDUT];
    int mt [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        param_updown_counter #(
            .WIDTH    (4),
            .MODULUS  (MODS[g]),
            .PRESCALE (PRESCALE_OF(g)),
            .SATURATE (SATS[g])
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .load     (load),
            .load_val (load_val),
            .en       (en),
            .up       (up),
            .count    (cnt[g]),
            .tc       (tcs[g])
        );
    end

    function automatic int unsigned PRESCALE_OF(input int g);
        return PRES[g];
    endfunction

    typedef struct {
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic       e;
        logic       u;
        logic [3:0] xc;
        logic       xt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [3:0] v,
                         input logic e, input logic u);
        clear = c; load = l; load_val = v; en = e; up = u;
    endtask

    task automatic model_zero();
        for (int i = 0; i < NDUT; i++) begin
            mc[i] = 0; mp[i] = 0; mt[i] = 0;
        end
    endtask

    // Behaviour straight from the rules: priority, phase, modular stepping
    task automatic model_edge();
        for (int i = 0; i < NDUT; i++) begin
            mt[i] = 0;
            if (clear) begin
                mc[i] = 0; mp[i] = 0;
            end else if (load) begin
                mc[i] = (int'(load_val) < MODS[i]) ? int'(load_val) : MODS[i] - 1;
                mp[i] = 0;
            end else if (en) begin
                mp[i] = (mp[i] + 1) % PRES[i];
                if (mp[i] == 0) begin
                    if (up && mc[i] == MODS[i] - 1) mt[i] = 1;
                    if (!up && mc[i] == 0) mt[i] = 1;
                    if (!(mt[i] == 1 && SATS[i] == 1))
                        mc[i] = up ? (mc[i] + 1) % MODS[i] : (mc[i] + MODS[i] - 1) % MODS[i];
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("%s cnt%0d", tag, i), 32'(cnt[i]), mc[i]);
            chk($sformatf("%s tc%0d", tag, i), 32'(tcs[i]), mt[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all("model");
    endtask

    // Reset pulse placed between edges; outputs must clear before the next edge
    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        model_zero();
        check_all("async reset");
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 4'd0, 0, 0);
        model_zero();
        #12;
        check_all("reset state");
        reset = 1'b0;

        // table: W=4 M=16 P=1 wrap instance
        for (int i = 0; i < 17; i++)
            tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'((i + 1) % 16), ((i + 1) % 16) == 0});
        tbl.push_back('{1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0});
        foreach (tbl[k]) begin
            drive(tbl[k].clr, tbl[k].ld, tbl[k].lv, tbl[k].e, tbl[k].u);
            tick();
            chk($sformatf("vec%0d cnt", k), 32'(cnt[0]), 32'(tbl[k].xc));
            chk($sformatf("vec%0d tc", k), 32'(tcs[0]), 32'(tbl[k].xt));
        end

        // M=10 down-count wrap, then clamped load
        async_reset();
        drive(0, 1, 4'd3, 0, 0); tick();
        chk("t2 load3", 32'(cnt[1]), 3);
        drive(0, 0, 4'd0, 1, 0);
        tick(); chk("t2 c2", 32'(cnt[1]), 2); chk("t2 tc2", 32'(tcs[1]), 0);
        tick(); chk("t2 c1", 32'(cnt[1]), 1);
        tick(); chk("t2 c0", 32'(cnt[1]), 0); chk("t2 tc0", 32'(tcs[1]), 0);
        tick(); chk("t2 c9", 32'(cnt[1]), 9); chk("t2 tc9", 32'(tcs[1]), 1);
        drive(0, 1, 4'd12, 0, 0); tick();
        chk("t2 clamp", 32'(cnt[1]), 9); chk("t2 clamp tc", 32'(tcs[1]), 0);

        // M=10 saturate at the top
        async_reset();
        drive(0, 1, 4'd8, 0, 1); tick();
        drive(0, 0, 4'd0, 1, 1);
        tick(); chk("t3 c a", 32'(cnt[2]), 9); chk("t3 tc a", 32'(tcs[2]), 0);
        tick(); chk("t3 c b", 32'(cnt[2]), 9); chk("t3 tc b", 32'(tcs[2]), 1);
        tick(); chk("t3 c c", 32'(cnt[2]), 9); chk("t3 tc c", 32'(tcs[2]), 1);

        // P=3 prescaler, en freeze, load priority over step
        async_reset();
        drive(0, 0, 4'd0, 1, 1);
        tick(); chk("t4 e1", 32'(cnt[3]), 0);
        tick(); chk("t4 e2", 32'(cnt[3]), 0);
        tick(); chk("t4 e3", 32'(cnt[3]), 1);
        tick();
        drive(0, 0, 4'd0, 0, 1);
        tick(); tick(); chk("t4 frozen", 32'(cnt[3]), 1);
        drive(0, 0, 4'd0, 1, 1);
        tick(); chk("t4 resume1", 32'(cnt[3]), 1);
        tick(); chk("t4 resume2", 32'(cnt[3]), 2);
        tick(); tick();
        drive(0, 1, 4'd5, 1, 1); tick();
        chk("t5 load", 32'(cnt[3]), 5); chk("t5 load tc", 32'(tcs[3]), 0);
        drive(0, 0, 4'd0, 1, 1);
        tick(); tick(); chk("t5 phase cleared", 32'(cnt[3]), 5);
        tick(); chk("t5 step", 32'(cnt[3]), 6);
        drive(1, 1, 4'd5, 1, 1); tick();
        chk("t5 clear wins", 32'(cnt[3]), 0);

        // mid-operation async reset then fresh prescaler phase
        drive(0, 1, 4'd7, 0, 1); tick();
        drive(0, 0, 4'd0, 1, 1); tick();
        chk("t6 pre", 32'(cnt[3]), 7);
        async_reset();
        chk("t6 rst cnt", 32'(cnt[3]), 0);
        tick(); chk("t6 e1", 32'(cnt[3]), 0);
        tick(); chk("t6 e2", 32'(cnt[3]), 0);
        tick(); chk("t6 e3", 32'(cnt[3]), 1);

        // randomized run against the reference model
        begin
            logic dir;
            dir = 1'b1;
            for (int n = 0; n < 800; n++) begin
                if ($urandom_range(0, 19) == 0) dir = ~dir;
                drive($urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
                      4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, dir);
                tick();
                if ($urandom_range(0, 150) == 0) async_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
